npu_result_readback: RTL
========================

// Module: npu_result_readback
// PURPOSE
// - Return path from the NPU to the host: captures the 8-bit result stream on npu_top D_OUT into a byte FIFO.
// - Lets the host drain the FIFO as 32-bit words packed four bytes at a time.
// - It is the reader counterpart of the host write path that loads the image, conv and dense RAMs.
// - Sits beside memory_read in mem_top: its d_in is D_OUT, and readdata goes to the host bus.
// PARAMETERS
// - DEPTH  1024  FIFO depth in bytes; must be a power of 2.
// - AW     10    FIFO address width, equal to log2(DEPTH).
// - LEN_W  16    width of expect_len and of the internal capture counter.
// PORTS
// - clk         in   1      single clock for the whole block.
// - reset       in   1      asynchronous, active-low reset.
// - start       in   1      one-cycle pulse: clear FIFO and flags, then arm capture.
// - expect_len  in   LEN_W  number of result bytes to capture; sampled on start.
// - d_in        in   8      NPU result byte (D_OUT).
// - d_valid     in   1      d_in is valid this cycle.
// - rd_en       in   1      host read strobe, one cycle per access.
// - rd_addr     in   1      0 = data word (pops bytes), 1 = status word (no side effect).
// - readdata    out  32     registered read response.
// - done        out  1      high once expect_len bytes have been captured.
// - overflow    out  1      sticky: a byte was dropped because the FIFO was full.
// BEHAVIOUR
// - Reset (reset=0, async):
//   - state=IDLE; FIFO empty (wr_ptr=rd_ptr=count=0); captured=0.
//   - readdata=0, done=0, overflow=0, underflow=0.
// - FSM states IDLE, CAPTURE, DONE.
//   - IDLE: d_valid is ignored. start -> CAPTURE, or -> DONE if expect_len==0.
//   - CAPTURE: each d_valid increments captured, whether or not the byte is stored.
//     - Transition to DONE in the cycle where captured+1==expect_len and d_valid=1.
//     - done rises in the following cycle.
//   - DONE: d_valid is ignored; done=1 until the next start or reset.
//   - start in any state:
//     - Synchronously clears FIFO, captured, overflow and underflow; sets done=0.
//     - Re-arms capture as in IDLE.
//     - A d_valid in the same cycle as start is dropped.
// - Push: in CAPTURE with d_valid=1.
//   - If count<DEPTH: write mem[wr_ptr], then wr_ptr++.
//   - Otherwise drop the byte and set overflow=1 (sticky).
//   - Pointers wrap modulo DEPTH. count runs 0..DEPTH, with AW+1 bits.
// - Data read (rd_en=1, rd_addr=0):
//   - n = min(4, count), where count is the value before this cycle's push.
//   - Bytes are little-endian: the oldest byte goes to [7:0], the next to [15:8], and so on.
//   - Unused byte lanes are 0. rd_ptr += n and count -= n.
//   - If count==0: readdata=0 and underflow=1 (sticky).
// - Status read (rd_en=1, rd_addr=1):
//   - Fields: [AW:0]=count, [16]=done, [17]=overflow, [18]=underflow, [19]=(state==CAPTURE); all other bits 0.
//   - Values are taken before this cycle's updates.
// - Read latency:
//   - readdata is registered: valid in cycle T+1 for rd_en in cycle T.
//   - It holds its value until the next rd_en.
// - Simultaneous push and pop: both take effect; count_next = count + push - n.
//   - A byte pushed in cycle T is readable from cycle T+1 onward.
// - rd_en together with start: the pop is suppressed.
//   - readdata returns the pre-start status word, or 0 for a data read.
//   - The clear still takes effect.
// - Memory: one write port and four byte reads per cycle.
//   - Implement as 4 interleaved banks of DEPTH/4 bytes, indexed by ptr[1:0], or as registers.
//   - The read mux must handle rd_ptr not aligned to 4.
// TESTING
// - T1, reset:
//   - Assert reset=0 mid-capture.
//   - Expect readdata=0, done=0, overflow=0 and status count=0 on the next read.
// - T2, packed read:
//   - start with expect_len=8; push 8'h01..8'h08; wait for done=1.
//   - Two data reads return 32'h04030201 then 32'h08070605. Status then shows count=0, done=1.
// - T3, partial and underflow:
//   - expect_len=6; push 6 bytes 8'hA0..8'hA5.
//   - Reads return 32'hA3A2A1A0, then 32'h0000A5A4, then 32'h0, and the third read sets underflow.
// - T4, overflow:
//   - DEPTH=1024, expect_len=1030, push 1030 bytes with no reads.
//   - Expect overflow=1, done=1, count=1024; the first word read holds bytes 0..3.
// - T5, concurrent push and pop:
//   - Push a byte every cycle while issuing a data read every cycle, starting from count=2.
//   - Each read returns min(4, pre-push count) bytes; no byte is lost or duplicated; pointers wrap correctly.
// - T6, restart and zero length:
//   - start mid-capture with expect_len=0.
//   - Expect done=1 one cycle later, count=0, and later d_valid ignored.

Source files
------------

// File: rtl/npu_result_readback.sv
// Result readback path: captures NPU result bytes into a byte FIFO and lets the
// host drain it as little-endian packed 32-bit words or read a status word.
module npu_result_readback #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] expect_len,
  input  logic [7:0]       d_in,
  input  logic             d_valid,
  input  logic             rd_en,
  input  logic             rd_addr,
  output logic [31:0]      readdata,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [LEN_W-1:0] r_captured;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_readdata;
  logic             r_done;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_full;
  logic             w_store;
  logic             w_pop;
  logic [2:0]       w_n;
  logic [2:0]       w_pop_n;
  logic [31:0]      w_data_word;
  logic [31:0]      w_status_word;

  // A start cycle drops any concurrent byte and suppresses any pop.
  assign w_push  = (r_state == S_CAPTURE) && d_valid && !start;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_store = w_push && !w_full;
  assign w_pop   = rd_en && !rd_addr && !start;
  assign w_n     = (r_count >= CW'(4)) ? 3'd4 : r_count[2:0];
  assign w_pop_n = w_pop ? w_n : 3'd0;

  // Oldest byte lands in lane 0; lanes beyond the current fill level read as 0.
  always_comb begin
    w_data_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (CW'(k) < r_count) begin
        w_data_word[8*k +: 8] = r_mem[r_rd_ptr + AW'(k)];
      end
    end
  end

  always_comb begin
    w_status_word       = '0;
    w_status_word[AW:0] = r_count;
    w_status_word[16]   = r_done;
    w_status_word[17]   = r_overflow;
    w_status_word[18]   = r_underflow;
    w_status_word[19]   = (r_state == S_CAPTURE);
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = (expect_len == '0) ? S_DONE : S_CAPTURE;
    end else if ((r_state == S_CAPTURE) && d_valid &&
                 ((r_captured + LEN_W'(1)) == r_len)) begin
      w_state_next = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_captured  <= '0;
      r_len       <= '0;
      r_readdata  <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_done <= (w_state_next == S_DONE);
      if (start) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_captured  <= '0;
        r_len       <= expect_len;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
        if (rd_en) begin
          r_readdata <= rd_addr ? w_status_word : 32'h0;
        end
      end else begin
        if (w_push) begin
          r_captured <= r_captured + LEN_W'(1);
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
        end
        r_count  <= r_count + CW'(w_store) - CW'(w_pop_n);
        r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
        if (rd_en) begin
          if (rd_addr) begin
            r_readdata <= w_status_word;
          end else begin
            r_readdata <= w_data_word;
            if (r_count == '0) begin
              r_underflow <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign readdata = r_readdata;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule
